// File: rtl/la_sd_card_cmd.sv
// SD card CMD-line front end: receives 48-bit host command frames, presents them to the core,
// and transmits the core's optional 48-bit response after NCR idle clocks.
module la_sd_card_cmd #(
   parameter     TARGET = "DEFAULT",
   parameter int NCR    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sd_cmd_in,
   output logic        sd_cmd_out,
   output logic        sd_cmd_oe,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   input  logic        cmd_ready,
   input  logic        resp_valid,
   input  logic        resp_none,
   input  logic [5:0]  resp_index,
   input  logic [31:0] resp_data,
   output logic        resp_ready,
   output logic        crc_err,
   output logic        busy
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RX       = 3'd1;
   localparam logic [2:0] HOLD     = 3'd2;
   localparam logic [2:0] WAITRESP = 3'd3;
   localparam logic [2:0] GAP      = 3'd4;
   localparam logic [2:0] TX       = 3'd5;

   localparam logic [5:0] GAP_LAST = 6'(NCR - 1);

   function automatic logic [6:0] crc7_bit(input logic [6:0] crc, input logic din);
      logic fb;
      fb = crc[6] ^ din;
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] data);
      logic [6:0] crc;
      crc = 7'h00;
      for (int i = 39; i >= 0; i--) crc = crc7_bit(crc, data[i]);
      return crc;
   endfunction

   logic [2:0]  state_reg, state_next;
   logic [45:0] rx_reg;
   logic [46:0] rx_frame;
   logic [5:0]  bit_cnt_reg;
   logic [6:0]  crc_reg;
   logic [47:0] tx_reg;
   logic [47:0] resp_frame;
   logic [5:0]  gap_cnt_reg;
   logic        frame_ok;
   logic        cmd_valid_reg, crc_err_reg, oe_reg, out_reg, busy_reg;
   logic [5:0]  cmd_index_reg;
   logic [31:0] cmd_arg_reg;

   // rx_frame[k] is frame bit k once the end bit is on the line; the start bit is implicitly 0.
   assign rx_frame   = {rx_reg, sd_cmd_in};
   assign frame_ok   = rx_frame[46] & rx_frame[0] & (rx_frame[7:1] == crc_reg);
   assign resp_frame = {2'b00, resp_index, resp_data, crc7_40({2'b00, resp_index, resp_data}), 1'b1};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (!sd_cmd_in) state_next = RX;
         RX:       if (bit_cnt_reg == 6'd0) state_next = frame_ok ? HOLD : IDLE;
         HOLD:     if (cmd_ready) state_next = WAITRESP;
         WAITRESP: if (resp_valid) state_next = resp_none ? IDLE : GAP;
         GAP:      if (gap_cnt_reg == 6'd0) state_next = TX;
         TX:       if (bit_cnt_reg == 6'd0) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         rx_reg        <= '0;
         bit_cnt_reg   <= '0;
         crc_reg       <= '0;
         tx_reg        <= '0;
         gap_cnt_reg   <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_index_reg <= '0;
         cmd_arg_reg   <= '0;
         crc_err_reg   <= 1'b0;
         oe_reg        <= 1'b0;
         out_reg       <= 1'b1;
         busy_reg      <= 1'b0;
      end else begin
         state_reg   <= state_next;
         busy_reg    <= (state_next != IDLE);
         crc_err_reg <= 1'b0;
         case (state_reg)
            IDLE: if (!sd_cmd_in) begin
               rx_reg      <= '0;
               bit_cnt_reg <= 6'd46;
               crc_reg     <= '0;
            end
            RX: begin
               rx_reg      <= rx_frame[45:0];
               bit_cnt_reg <= bit_cnt_reg - 6'd1;
               if (bit_cnt_reg >= 6'd8) crc_reg <= crc7_bit(crc_reg, sd_cmd_in);
               if (bit_cnt_reg == 6'd0) begin
                  if (frame_ok) begin
                     cmd_valid_reg <= 1'b1;
                     cmd_index_reg <= rx_frame[45:40];
                     cmd_arg_reg   <= rx_frame[39:8];
                  end else begin
                     crc_err_reg <= 1'b1;
                  end
               end
            end
            HOLD: if (cmd_ready) cmd_valid_reg <= 1'b0;
            WAITRESP: if (resp_valid && !resp_none) begin
               tx_reg      <= resp_frame;
               gap_cnt_reg <= GAP_LAST;
            end
            // The first response bit is loaded on the last GAP edge so the pad sees it with oe.
            GAP: if (gap_cnt_reg == 6'd0) begin
               oe_reg      <= 1'b1;
               out_reg     <= tx_reg[47];
               tx_reg      <= {tx_reg[46:0], 1'b0};
               bit_cnt_reg <= 6'd47;
            end else begin
               gap_cnt_reg <= gap_cnt_reg - 6'd1;
            end
            TX: if (bit_cnt_reg == 6'd0) begin
               oe_reg  <= 1'b0;
               out_reg <= 1'b1;
            end else begin
               out_reg     <= tx_reg[47];
               tx_reg      <= {tx_reg[46:0], 1'b0};
               bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end
            default: ;
         endcase
      end
   end

   assign sd_cmd_out = out_reg;
   assign sd_cmd_oe  = oe_reg;
   assign cmd_valid  = cmd_valid_reg;
   assign cmd_index  = cmd_index_reg;
   assign cmd_arg    = cmd_arg_reg;
   assign crc_err    = crc_err_reg;
   assign busy       = busy_reg;
   assign resp_ready = (state_reg == WAITRESP);

endmodule

// File: doc/la_sd_card_cmd.md
LA_SD_CARD_CMD -- requirements
Module: la_sd_card_cmd

Interface
REQ-001 SHALL have parameter TARGET, default "DEFAULT", technology target.
REQ-002 SHALL have parameter NCR, default 2, range 2..64, idle cycles between the response handshake and the response start bit.
REQ-003 SHALL have port clk, input, 1 bit, SD bus clock and sole clock, rising edge only.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 SHALL have port sd_cmd_in, input, 1 bit, CMD line sampled from the pad.
REQ-006 SHALL have port sd_cmd_out, output, 1 bit, CMD line drive value.
REQ-007 SHALL have port sd_cmd_oe, output, 1 bit, CMD pad output enable.
REQ-008 SHALL have ports cmd_valid (output, 1), cmd_index (output, 6) and cmd_arg (output, 32) for the received command.
REQ-009 SHALL have port cmd_ready, input, 1 bit, core accepts the command.
REQ-010 SHALL have ports resp_valid (input, 1), resp_none (input, 1), resp_index (input, 6) and resp_data (input, 32), the response request from the core.
REQ-011 SHALL have port resp_ready, output, 1 bit, response accepted.
REQ-012 SHALL have port crc_err, output, 1 bit, one-cycle pulse on a rejected frame.
REQ-013 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RX, HOLD, WAITRESP, GAP and TX, all registered.
REQ-015 IDLE SHALL move to RX when sd_cmd_in samples 0 (start bit); the start bit counts as frame bit 47.
REQ-016 RX SHALL shift in the remaining 47 bits MSB-first, one per clk; the bit counter runs from 46 down to 0.
REQ-017 A frame SHALL be valid only if bit46=1 (host transmission bit), bit0=1 (end bit) and bits[7:1] equal CRC7 of bits[47:8].
- CRC7 polynomial: x^7+x^3+1.
- CRC7 initial value: 0.
REQ-018 On a valid frame, cmd_valid SHALL assert on the cycle after the end bit is sampled, with cmd_index=bits[45:40] and cmd_arg=bits[39:8]; state moves to HOLD.
REQ-019 On an invalid frame, crc_err SHALL pulse for the cycle after the end bit, cmd_valid SHALL stay 0, and state SHALL return to IDLE.
REQ-020 HOLD SHALL keep cmd_valid, cmd_index and cmd_arg stable until cmd_valid&cmd_ready; the next cycle enters WAITRESP with cmd_valid=0.
REQ-021 resp_ready SHALL be high only in WAITRESP; a handshake is resp_valid&resp_ready.
REQ-022 On a handshake with resp_none=1, state SHALL return to IDLE and nothing SHALL be transmitted.
REQ-023 On a handshake with resp_none=0, the block SHALL latch the frame and enter GAP.
- Frame layout: 0, 0, resp_index, resp_data, CRC7 of the first 40 bits, 1.
REQ-024 GAP SHALL last exactly NCR cycles, with sd_cmd_oe=0 and sd_cmd_out=1.
REQ-025 TX SHALL drive the 48 bits MSB-first, one per clk, with sd_cmd_oe=1 for exactly 48 consecutive cycles.
REQ-026 After TX, sd_cmd_oe SHALL return to 0 and state to IDLE.
REQ-027 sd_cmd_out SHALL be 1 whenever sd_cmd_oe=0.
REQ-028 sd_cmd_in SHALL be ignored in HOLD, WAITRESP, GAP and TX; start bits arriving there SHALL not be detected.
REQ-029 The next command SHALL be detectable from the first cycle back in IDLE.
REQ-030 All outputs SHALL be driven from flops; no combinational path from sd_cmd_in to any output.
- Exception: resp_ready, which is decoded from state only.

Reset
REQ-031 While reset=1, the block SHALL hold state=IDLE and all outputs at reset values, taking effect immediately and asynchronously.
- Reset values: sd_cmd_oe=0, sd_cmd_out=1, cmd_valid=0, cmd_index=0, cmd_arg=0, resp_ready=0, crc_err=0, busy=0.
REQ-032 Reset asserted mid-RX, mid-GAP or mid-TX SHALL abort the frame with no residual drive and no cmd_valid.
- The first start bit after deassertion SHALL be received normally.

Verification
REQ-033 Drive CMD0 frame 0x40_00000000_95 -> cmd_valid one cycle after the end bit, cmd_index=0, cmd_arg=0, crc_err=0.
REQ-034 Drive CMD17 frame 0x51_00000000_55, then cmd_ready, then resp_valid with resp_index=17 and resp_data=0x00000900.
- Required: sd_cmd_oe low for exactly 2 cycles after the handshake, then high for 48 cycles.
- Required: transmitted bits = 0x11_00000900 plus correct CRC7 and end bit 1, checked against a reference CRC7 model.
REQ-035 Drive CMD8 frame 0x48_000001AA_87 with one CRC bit flipped -> crc_err pulses once, cmd_valid=0, busy=0 on the following cycle.
REQ-036 Drive CMD0 with a resp_none=1 handshake -> sd_cmd_oe never asserts and busy=0 the cycle after the handshake.
REQ-037 Pulse reset at TX bit 20 -> sd_cmd_oe=0 within the reset cycle.
- Required: a subsequent CMD0 frame is decoded correctly.
REQ-038 Drive a start bit on sd_cmd_in during GAP and TX -> ignored, no cmd_valid; a back-to-back command sent after TX completes is received.
